// File: rtl/poly_operand_driver.sv
// Host-side initiator for the poly unit: latches A, B, C, X on start, feeds them to the
// unit one at a time behind timed go pulses, then captures the unit's result.
module poly_operand_driver #(
    parameter int DATA_W      = 8,
    parameter int GO_HIGH_CYC = 2,
    parameter int GO_LOW_CYC  = 2,
    parameter int RESULT_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] c_in,
    input  logic [DATA_W-1:0] x_in,
    output logic              go,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] result_in,
    output logic [DATA_W-1:0] result_out,
    output logic              busy,
    output logic              done
);

    localparam int MAX_GO  = (GO_HIGH_CYC > GO_LOW_CYC) ? GO_HIGH_CYC : GO_LOW_CYC;
    localparam int MAX_CYC = (MAX_GO > RESULT_WAIT) ? MAX_GO : RESULT_WAIT;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Phase counters load N-1 and count down, so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HI_LOAD   = CNT_W'(GO_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LOAD   = CNT_W'(GO_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RESULT_WAIT > 0) ? RESULT_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE_HI,
        S_PULSE_LO,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        next_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_q [4];
    logic [DATA_W-1:0] op_d [4];
    logic              go_q, go_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            go_q     <= 1'b0;
            data_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            go_q     <= go_d;
            data_q   <= data_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            for (int i = 0; i < 4; i++) begin
                op_q[i] <= op_d[i];
            end
        end
    end

    // Every output is computed one cycle ahead here so that all of them come straight from flops.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        go_d     = go_q;
        data_d   = data_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        next_idx = idx_q + 2'd1;

        case (state_q)
            // CAPTURE behaves as IDLE so a held start runs transactions back to back.
            S_IDLE, S_CAPTURE: begin
                state_d = S_IDLE;
                go_d    = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    op_d[0] = a_in;
                    op_d[1] = b_in;
                    op_d[2] = c_in;
                    op_d[3] = x_in;
                    idx_d   = 2'd0;
                    data_d  = a_in;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                go_d    = 1'b1;
                cnt_d   = HI_LOAD;
                state_d = S_PULSE_HI;
            end
            S_PULSE_HI: begin
                if (cnt_q == '0) begin
                    go_d    = 1'b0;
                    cnt_d   = LO_LOAD;
                    state_d = S_PULSE_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE_LO: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q != 2'd3) begin
                    idx_d   = next_idx;
                    data_d  = op_q[next_idx];
                    state_d = S_SETUP;
                end else if (RESULT_WAIT == 0) begin
                    result_d = result_in;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_CAPTURE;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    result_d = result_in;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign go         = go_q;
    assign data_out   = data_q;
    assign result_out = result_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_poly_operand_driver.sv
// Randomised bench for poly_operand_driver with a poly-unit model (A*A+C mod 256) that
// listens to go/data_out; expectations come from the operand rules and cycle formulas.
module tb_poly_operand_driver;

    localparam int GH_DEF  = 2;
    localparam int GL_DEF  = 2;
    localparam int P_DEF   = 1 + GH_DEF + GL_DEF;
    localparam int LAT_DEF = 4 * P_DEF + 4 + 1;
    localparam int GH_S    = 1;
    localparam int GL_S    = 1;
    localparam int P_S     = 1 + GH_S + GL_S;
    localparam int LAT_S   = 4 * P_S + 3 + 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] aIn, bIn, cIn, xIn;
    logic [7:0] resultIn;
    logic       sel;

    logic       go1, busy1, done1;
    logic [7:0] data1, res1;
    logic       go2, busy2, done2;
    logic [7:0] data2, res2;

    logic       goS, busyS, doneS;
    logic [7:0] dataS, resS;

    int checks = 0;
    int fails  = 0;

    logic       goH   [0:255];
    logic       busyH [0:255];
    logic       doneH [0:255];
    logic [7:0] dataH [0:255];
    logic [7:0] resH  [0:255];

    int         riseQ[$];
    int         widthQ[$];
    logic [7:0] riseDataQ[$];
    bit         stableQ[$];

    poly_operand_driver #(
        .DATA_W(8), .GO_HIGH_CYC(GH_DEF), .GO_LOW_CYC(GL_DEF), .RESULT_WAIT(4)
    ) dutDef (
        .clk(clk), .reset(reset), .start(start),
        .a_in(aIn), .b_in(bIn), .c_in(cIn), .x_in(xIn),
        .go(go1), .data_out(data1), .result_in(resultIn),
        .result_out(res1), .busy(busy1), .done(done1)
    );

    poly_operand_driver #(
        .DATA_W(8), .GO_HIGH_CYC(GH_S), .GO_LOW_CYC(GL_S), .RESULT_WAIT(3)
    ) dutShort (
        .clk(clk), .reset(reset), .start(start),
        .a_in(aIn), .b_in(bIn), .c_in(cIn), .x_in(xIn),
        .go(go2), .data_out(data2), .result_in(resultIn),
        .result_out(res2), .busy(busy2), .done(done2)
    );

    assign goS   = sel ? go2   : go1;
    assign busyS = sel ? busy2 : busy1;
    assign doneS = sel ? done2 : done1;
    assign dataS = sel ? data2 : data1;
    assign resS  = sel ? res2  : res1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Poly unit model: takes data_in on each go rise, result valid after the 4th pulse falls.
    logic [7:0] mOps [4];
    int         mN;
    logic       mPrevGo;
    logic [15:0] mPoly;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            mN      = 0;
            mPrevGo = 1'b0;
        end else begin
            if (goS && !mPrevGo) begin
                if (mN < 4) begin
                    mOps[mN] = dataS;
                    mN++;
                end
                if (mN == 1) resultIn = 8'($urandom);
            end
            if (!goS && mPrevGo && mN == 4) begin
                mPoly    = {8'd0, mOps[0]} * {8'd0, mOps[0]} + {8'd0, mOps[2]};
                resultIn = mPoly[7:0];
                mN       = 0;
            end
            mPrevGo = goS;
        end
    end

    function automatic logic [7:0] polyRef(input logic [7:0] a, input logic [7:0] c);
        int t;
        t = int'(a) * int'(a) + int'(c);
        return 8'(t % 256);
    endfunction

    task automatic startTxn(input logic [7:0] a, b, c, x);
        aIn   = a;
        bIn   = b;
        cIn   = c;
        xIn   = x;
        start = 1'b1;
    endtask

    // Sample s is taken at the falling edge after the s-th rising edge counted from the start edge.
    task automatic observe(input int n, input bit holdStart, input int extra1, input int extra2,
                           input bit scramble);
        for (int s = 1; s <= n; s++) begin
            @(negedge clk);
            goH[s]   = goS;
            busyH[s] = busyS;
            doneH[s] = doneS;
            dataH[s] = dataS;
            resH[s]  = resS;
            start    = holdStart || (s == extra1) || (s == extra2);
            if (scramble) begin
                aIn = 8'($urandom);
                bIn = 8'($urandom);
                cIn = 8'($urandom);
                xIn = 8'($urandom);
            end
        end
    endtask

    task automatic extractPulses(input int n);
        int w;
        bit st;
        riseQ.delete();
        widthQ.delete();
        riseDataQ.delete();
        stableQ.delete();
        for (int s = 1; s <= n; s++) begin
            if (goH[s] && (s == 1 || !goH[s-1])) begin
                w  = 0;
                st = 1'b1;
                for (int t = s; t <= n && goH[t]; t++) begin
                    w++;
                    if (dataH[t] !== dataH[s]) st = 1'b0;
                end
                riseQ.push_back(s);
                widthQ.push_back(w);
                riseDataQ.push_back(dataH[s]);
                stableQ.push_back(st);
            end
        end
    endtask

    task automatic countDone(input int n, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int s = 1; s <= n; s++) begin
            if (doneH[s]) begin
                cnt++;
                if (first < 0) first = s;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({go1, busy1, done1} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got go/busy/done=%b required 000", {go1, busy1, done1});
        end
        checks++;
        if (data1 !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_data: got %h required 00", data1);
        end
        checks++;
        if (res1 !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_result: got %h required 00", res1);
        end
        checks++;
        if ({go2, busy2, done2, data2, res2} !== 19'd0) begin
            fails++;
            $display("[TB] FAIL reset_short: got %h required 0", {go2, busy2, done2, data2, res2});
        end
    endtask

    task automatic test_basic;
        logic [7:0] ops [4];
        int dn, first;
        ops[0] = 8'd3; ops[1] = 8'd0; ops[2] = 8'd5; ops[3] = 8'd2;
        startTxn(ops[0], ops[1], ops[2], ops[3]);
        observe(30, 1'b0, 0, 0, 1'b0);
        extractPulses(30);
        countDone(30, dn, first);
        checks++;
        if (busyH[1] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_busy: got %b required 1", busyH[1]);
        end
        checks++;
        if (riseQ.size() != 4) begin
            fails++;
            $display("[TB] FAIL basic_pulse_count: got %0d required 4", riseQ.size());
        end
        for (int k = 0; k < 4 && k < riseQ.size(); k++) begin
            checks++;
            if (riseDataQ[k] !== ops[k] || !stableQ[k]) begin
                fails++;
                $display("[TB] FAIL basic_data%0d: got %h stable=%b required %h", k, riseDataQ[k],
                         stableQ[k], ops[k]);
            end
            checks++;
            if (widthQ[k] != GH_DEF || riseQ[k] != 2 + k * P_DEF) begin
                fails++;
                $display("[TB] FAIL basic_pulse%0d: got width %0d at %0d required width %0d at %0d",
                         k, widthQ[k], riseQ[k], GH_DEF, 2 + k * P_DEF);
            end
            if (k > 0) begin
                checks++;
                if (riseQ[k] - riseQ[k-1] - widthQ[k-1] < GL_DEF) begin
                    fails++;
                    $display("[TB] FAIL basic_gap%0d: got %0d low cycles required at least %0d", k,
                             riseQ[k] - riseQ[k-1] - widthQ[k-1], GL_DEF);
                end
            end
        end
        checks++;
        if (first != LAT_DEF || dn != 1) begin
            fails++;
            $display("[TB] FAIL basic_done: got first %0d count %0d required %0d count 1", first, dn,
                     LAT_DEF);
        end
        checks++;
        if (resH[LAT_DEF] !== 8'h0E || busyH[LAT_DEF] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_result: got %h busy %b required 0e busy 0", resH[LAT_DEF],
                     busyH[LAT_DEF]);
        end
        checks++;
        if (resH[30] !== 8'h0E) begin
            fails++;
            $display("[TB] FAIL basic_hold: got %h required 0e", resH[30]);
        end
    endtask

    task automatic test_random;
        logic [7:0] ops [4];
        int dn, first;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 4; k++) ops[k] = 8'($urandom);
            startTxn(ops[0], ops[1], ops[2], ops[3]);
            observe(30, 1'b0, 0, 0, 1'b0);
            extractPulses(30);
            countDone(30, dn, first);
            checks++;
            if (riseQ.size() != 4) begin
                fails++;
                $display("[TB] FAIL random_pulses%0d: got %0d required 4", it, riseQ.size());
            end
            for (int k = 0; k < 4 && k < riseQ.size(); k++) begin
                checks++;
                if (riseDataQ[k] !== ops[k]) begin
                    fails++;
                    $display("[TB] FAIL random_data%0d_%0d: got %h required %h", it, k,
                             riseDataQ[k], ops[k]);
                end
            end
            checks++;
            if (first != LAT_DEF || dn != 1 || resH[LAT_DEF] !== polyRef(ops[0], ops[2])) begin
                fails++;
                $display("[TB] FAIL random_result%0d: got %h at %0d (count %0d) required %h at %0d",
                         it, resH[LAT_DEF], first, dn, polyRef(ops[0], ops[2]), LAT_DEF);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] wa [2];
        logic [7:0] wc [2];
        logic [7:0] we [2];
        int dn, first;
        wa[0] = 8'd16;  wc[0] = 8'd1;   we[0] = 8'h01;
        wa[1] = 8'd255; wc[1] = 8'd255; we[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            startTxn(wa[i], 8'($urandom), wc[i], 8'($urandom));
            observe(30, 1'b0, 0, 0, 1'b0);
            countDone(30, dn, first);
            checks++;
            if (first != LAT_DEF || resH[LAT_DEF] !== we[i]) begin
                fails++;
                $display("[TB] FAIL wrap%0d: got %h at %0d required %h at %0d", i, resH[LAT_DEF],
                         first, we[i], LAT_DEF);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [7:0] ops [4];
        int dn, first;
        for (int k = 0; k < 4; k++) ops[k] = 8'($urandom);
        startTxn(ops[0], ops[1], ops[2], ops[3]);
        observe(45, 1'b0, 5, 20, 1'b1);
        extractPulses(45);
        countDone(45, dn, first);
        checks++;
        if (dn != 1 || first != LAT_DEF) begin
            fails++;
            $display("[TB] FAIL ignore_done: got count %0d first %0d required count 1 first %0d", dn,
                     first, LAT_DEF);
        end
        checks++;
        if (riseQ.size() != 4) begin
            fails++;
            $display("[TB] FAIL ignore_pulses: got %0d required 4", riseQ.size());
        end
        for (int k = 0; k < 4 && k < riseQ.size(); k++) begin
            checks++;
            if (riseDataQ[k] !== ops[k]) begin
                fails++;
                $display("[TB] FAIL ignore_data%0d: got %h required %h", k, riseDataQ[k], ops[k]);
            end
        end
        checks++;
        if (resH[LAT_DEF] !== polyRef(ops[0], ops[2])) begin
            fails++;
            $display("[TB] FAIL ignore_result: got %h required %h", resH[LAT_DEF],
                     polyRef(ops[0], ops[2]));
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ops [4];
        int doneAt[$];
        for (int k = 0; k < 4; k++) ops[k] = 8'($urandom);
        startTxn(ops[0], ops[1], ops[2], ops[3]);
        observe(80, 1'b1, 0, 0, 1'b0);
        extractPulses(80);
        for (int s = 1; s <= 80; s++) if (doneH[s]) doneAt.push_back(s);
        checks++;
        if (doneAt.size() != 3) begin
            fails++;
            $display("[TB] FAIL b2b_done_count: got %0d required 3", doneAt.size());
        end
        for (int i = 0; i < 3 && i < doneAt.size(); i++) begin
            checks++;
            if (doneAt[i] != LAT_DEF * (i + 1) || resH[doneAt[i]] !== polyRef(ops[0], ops[2])) begin
                fails++;
                $display("[TB] FAIL b2b_done%0d: got %h at %0d required %h at %0d", i,
                         resH[doneAt[i]], doneAt[i], polyRef(ops[0], ops[2]), LAT_DEF * (i + 1));
            end
        end
        checks++;
        if (riseQ.size() < 12) begin
            fails++;
            $display("[TB] FAIL b2b_pulses: got %0d required at least 12", riseQ.size());
        end
        for (int i = 0; i < 12 && i < riseQ.size(); i++) begin
            checks++;
            if (riseDataQ[i] !== ops[i % 4] || riseQ[i] != 2 + (i / 4) * LAT_DEF + (i % 4) * P_DEF)
            begin
                fails++;
                $display("[TB] FAIL b2b_pulse%0d: got %h at %0d required %h at %0d", i,
                         riseDataQ[i], riseQ[i], ops[i % 4],
                         2 + (i / 4) * LAT_DEF + (i % 4) * P_DEF);
            end
        end
        observe(30, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic [7:0] b, x;
        int dn, first, goCount;
        startTxn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        observe(2 + 2 * P_DEF + 1, 1'b0, 0, 0, 1'b0);
        checks++;
        if (goH[2 + 2 * P_DEF + 1] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset_pre: got go %b required 1 during C pulse",
                     goH[2 + 2 * P_DEF + 1]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (go1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_async: got go %b busy %b done %b required 0 0 0", go1, busy1,
                     done1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        observe(40, 1'b0, 0, 0, 1'b0);
        countDone(40, dn, first);
        goCount = 0;
        for (int s = 1; s <= 40; s++) if (goH[s]) goCount++;
        checks++;
        if (dn != 0 || goCount != 0) begin
            fails++;
            $display("[TB] FAIL midreset_quiet: got done %0d go %0d required 0 0", dn, goCount);
        end
        b = 8'($urandom);
        x = 8'($urandom);
        startTxn(8'd4, b, 8'd1, x);
        observe(30, 1'b0, 0, 0, 1'b0);
        countDone(30, dn, first);
        checks++;
        if (first != LAT_DEF || resH[LAT_DEF] !== 8'h11) begin
            fails++;
            $display("[TB] FAIL midreset_after: got %h at %0d required 11 at %0d", resH[LAT_DEF],
                     first, LAT_DEF);
        end
    endtask

    task automatic test_short;
        logic [7:0] ops [4];
        int dn, first;
        sel = 1'b1;
        @(negedge clk);
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 4; k++) ops[k] = 8'($urandom);
            startTxn(ops[0], ops[1], ops[2], ops[3]);
            observe(22, 1'b0, 0, 0, 1'b0);
            extractPulses(22);
            countDone(22, dn, first);
            checks++;
            if (riseQ.size() != 4) begin
                fails++;
                $display("[TB] FAIL short_pulses%0d: got %0d required 4", it, riseQ.size());
            end
            for (int k = 0; k < 4 && k < riseQ.size(); k++) begin
                checks++;
                if (widthQ[k] != GH_S || riseQ[k] != 2 + k * P_S || riseDataQ[k] !== ops[k]) begin
                    fails++;
                    $display("[TB] FAIL short_pulse%0d_%0d: got w%0d at %0d data %h required w%0d at %0d data %h",
                             it, k, widthQ[k], riseQ[k], riseDataQ[k], GH_S, 2 + k * P_S, ops[k]);
                end
            end
            checks++;
            if (first != LAT_S || dn != 1 || resH[LAT_S] !== polyRef(ops[0], ops[2])) begin
                fails++;
                $display("[TB] FAIL short_result%0d: got %h at %0d (count %0d) required %h at %0d",
                         it, resH[LAT_S], first, dn, polyRef(ops[0], ops[2]), LAT_S);
            end
        end
    endtask

    initial begin
        #60000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sel      = 1'b0;
        start    = 1'b0;
        reset    = 1'b1;
        resultIn = 8'h00;
        aIn      = 8'h00;
        bIn      = 8'h00;
        cIn      = 8'h00;
        xIn      = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_random();
        test_wrap();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_short();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/poly_operand_driver.md
Name: poly_operand_driver

Overview:
- Initiator for the polynomial unit's go/data_in load handshake.
- Accepts four operands (A, B, C, X) in parallel on a single start strobe.
- Drives them one at a time to the poly unit's data_in with timed go pulses, in order A, B, C, X.
- Waits for the unit to compute, captures its data_result, and reports the result with a one-cycle done pulse.
- Sits between a host/test controller and the poly unit. Replaces manual switch and key operation.

Parameters:
- DATA_W, 8: operand and result width.
- GO_HIGH_CYC, 2: cycles go is held high per operand. Minimum 1.
- GO_LOW_CYC, 2: cycles go is held low after each pulse. Minimum 1.
- RESULT_WAIT, 4: cycles after the last low phase before result_in is sampled. GO_LOW_CYC + RESULT_WAIT must be at least 4.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a transaction; sampled only in IDLE.
- a_in  in  DATA_W  operand A.
- b_in  in  DATA_W  operand B.
- c_in  in  DATA_W  operand C.
- x_in  in  DATA_W  operand X.
- go  out  1  handshake strobe to the poly unit (active high).
- data_out  out  DATA_W  operand bus to the poly unit's data_in.
- result_in  in  DATA_W  poly unit's data_result.
- result_out  out  DATA_W  captured result; holds until the next capture.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when result_out is updated.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset (asynchronous, immediate): state=IDLE; go=0, data_out=0, result_out=0, busy=0, done=0; operand registers and counters = 0.
- All outputs are registered.
- States: IDLE, SETUP, PULSE_HI, PULSE_LO, WAIT, CAPTURE.
  - Operand index idx, 2 bits, counts 0..3 = A, B, C, X.
  - Phase counter cnt is wide enough for max(GO_HIGH_CYC, GO_LOW_CYC, RESULT_WAIT).
- IDLE:
  - On start=1: latch a_in..x_in into shadow registers, set idx=0, go to SETUP, busy=1.
  - Operand inputs are ignored after this latch.
- SETUP (1 cycle): data_out=operand[idx], go=0. Next: PULSE_HI.
- PULSE_HI (GO_HIGH_CYC cycles): go=1, data_out held. Next: PULSE_LO.
- PULSE_LO (GO_LOW_CYC cycles): go=0, data_out held.
  - If idx<3: idx++, next SETUP.
  - If idx=3: next WAIT.
- WAIT (RESULT_WAIT cycles): go=0, data_out held.
- CAPTURE (1 cycle):
  - On entering this state, result_out<=result_in, done=1, busy=0.
  - Next edge: done=0, state=IDLE.
  - CAPTURE counts as IDLE for start sampling: start=1 during the done cycle begins a new transaction with latch and SETUP at that edge.
- Latency: done asserts 4*(1+GO_HIGH_CYC+GO_LOW_CYC)+RESULT_WAIT+1 cycles after the edge at which start is sampled. Defaults: 25 cycles.
- go is never high for two operands without at least GO_LOW_CYC low cycles between pulses.
- data_out changes only at the SETUP entry edge. It is stable for the entire go pulse.
- start while busy=1: ignored. No queueing and no error flag.
- No arithmetic is performed here. result_out is an exact DATA_W copy of result_in.
- Reset mid-transaction: go drops immediately, the transaction is discarded, no done pulse. The poly unit must be reset by the same event so both ends realign at operand A.

Test Plan:
- Default params, A=3, B=0, C=5, X=2, start pulse; bench uses a cycle-accurate poly unit model (A*A+C, mod 256) -> four go pulses, each 2 high / 2 low; data_out sequence 3, 0, 5, 2; done at cycle 25; result_out=0x0E.
- Wrap-around: A=16, C=1 -> result_out=0x01. A=255, C=255 -> 255*255 mod 256 = 1, +255 = 0 -> result_out=0x00.
- start pulsed again at cycles 5 and 20 of an active transaction -> ignored; exactly one done; shadow operands unchanged even though a_in changed.
- start held high continuously -> back-to-back transactions; a new SETUP begins at the done-cycle edge; done every 25 cycles.
- Reset asserted asynchronously mid-PULSE_HI for operand C -> go=0 and busy=0 immediately, no done. After release, a full transaction with A=4, C=1 gives result_out=0x11.
- GO_HIGH_CYC=1, GO_LOW_CYC=1, RESULT_WAIT=3 -> go pulses exactly 1 cycle wide; done at cycle 16; result correct against the model.
